// File: rtl/pc_fetch_sequencer.sv
// Instruction fetch sequencer: fetches from imem at pc, issues to decode, handles
// redirects (including those arriving mid-fetch), halting and misaligned targets.
module pc_fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        halt_req,
   output logic        halted,
   output logic        misaligned_err,
   output logic [31:0] instr_count
);

   typedef enum logic [1:0] {StIdle, StFetch, StIssue, StHalted} state_t;

   state_t      state;
   logic [31:0] pc;
   logic        redirect_pending;
   logic [31:0] redirect_target;

   logic        target_misaligned;
   logic [31:0] next_target;
   logic [31:0] pc_inc;

   assign target_misaligned = (branch_target[1:0] != 2'b00);
   // A fresh branch overrides any redirect already pending.
   assign next_target       = branch_taken ? branch_target : redirect_target;
   assign pc_inc            = pc + 32'd4;

   always_ff @(posedge clock) begin
      if (reset) begin
         state            <= StIdle;
         pc               <= RESET_PC;
         redirect_pending <= 1'b0;
         redirect_target  <= 32'h0;
         imem_req         <= 1'b0;
         imem_addr        <= 32'h0;
         instr_valid      <= 1'b0;
         instr_out        <= 32'h0;
         pc_out           <= 32'h0;
         halted           <= 1'b0;
         misaligned_err   <= 1'b0;
         instr_count      <= 32'h0;
      end else begin
         case (state)
            StIdle: begin
               if (halt_req) begin
                  state  <= StHalted;
                  halted <= 1'b1;
               end else begin
                  state     <= StFetch;
                  imem_req  <= 1'b1;
                  imem_addr <= pc;
               end
            end
            StFetch: begin
               if (branch_taken && target_misaligned) begin
                  state            <= StHalted;
                  misaligned_err   <= 1'b1;
                  halted           <= 1'b1;
                  imem_req         <= 1'b0;
                  redirect_pending <= 1'b0;
               end else if (imem_ready) begin
                  if (branch_taken || redirect_pending) begin
                     // Returned word belongs to a squashed path; refetch at the target.
                     pc               <= next_target;
                     imem_addr        <= next_target;
                     redirect_pending <= 1'b0;
                  end else begin
                     state       <= StIssue;
                     instr_out   <= imem_rdata;
                     pc_out      <= pc;
                     instr_valid <= 1'b1;
                     imem_req    <= 1'b0;
                  end
               end else if (branch_taken) begin
                  redirect_pending <= 1'b1;
                  redirect_target  <= branch_target;
               end
            end
            StIssue: begin
               if (branch_taken) begin
                  instr_valid <= 1'b0;
                  instr_count <= instr_count + 32'd1;
                  if (target_misaligned) begin
                     state          <= StHalted;
                     misaligned_err <= 1'b1;
                     halted         <= 1'b1;
                  end else begin
                     state     <= StFetch;
                     pc        <= branch_target;
                     imem_req  <= 1'b1;
                     imem_addr <= branch_target;
                  end
               end else if (!stall) begin
                  instr_valid <= 1'b0;
                  instr_count <= instr_count + 32'd1;
                  pc          <= pc_inc;
                  if (halt_req) begin
                     state  <= StHalted;
                     halted <= 1'b1;
                  end else begin
                     state     <= StFetch;
                     imem_req  <= 1'b1;
                     imem_addr <= pc_inc;
                  end
               end
            end
            StHalted: begin
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios plus random traffic, all checked
// cycle by cycle against a behavioural model of the fetch/issue protocol.
module tb_pc_fetch_sequencer;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        instr_valid;
   logic [31:0] instr_out;
   logic [31:0] pc_out;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        halt_req = 1'b0;
   logic        halted;
   logic        misaligned_err;
   logic [31:0] instr_count;

   pc_fetch_sequencer #(.RESET_PC(RESET_PC)) dut (
      .clock          (clock),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr_out      (instr_out),
      .pc_out         (pc_out),
      .stall          (stall),
      .branch_taken   (branch_taken),
      .branch_target  (branch_target),
      .halt_req       (halt_req),
      .halted         (halted),
      .misaligned_err (misaligned_err),
      .instr_count    (instr_count)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Behavioural model: which protocol phase the sequencer is in, plus architectural values.
   typedef enum int {PhIdle, PhFetch, PhIssue, PhHalted} phase_t;
   phase_t      m_phase;
   logic [31:0] m_pc, m_tgt, m_instr, m_pcout, m_count;
   logic        m_pend, m_err;

   task automatic model_reset();
      m_phase = PhIdle;
      m_pc    = RESET_PC;
      m_tgt   = 32'h0;
      m_pend  = 1'b0;
      m_instr = 32'h0;
      m_pcout = 32'h0;
      m_count = 32'h0;
      m_err   = 1'b0;
   endtask

   task automatic model_step(input bit rst, input bit rdy, input bit stl, input bit br,
                             input bit hlt, input logic [31:0] bt, input logic [31:0] rd);
      if (rst) begin
         model_reset();
         return;
      end
      case (m_phase)
         PhIdle:  m_phase = hlt ? PhHalted : PhFetch;
         PhFetch: begin
            if (br && bt[1:0] != 2'b00) begin
               m_err   = 1'b1;
               m_pend  = 1'b0;
               m_phase = PhHalted;
            end else if (rdy) begin
               if (br) m_pc = bt;
               else if (m_pend) m_pc = m_tgt;
               else begin
                  m_instr = rd;
                  m_pcout = m_pc;
                  m_phase = PhIssue;
               end
               m_pend = 1'b0;
            end else if (br) begin
               m_pend = 1'b1;
               m_tgt  = bt;
            end
         end
         PhIssue: begin
            if (br) begin
               m_count = m_count + 1;
               if (bt[1:0] != 2'b00) begin
                  m_err   = 1'b1;
                  m_phase = PhHalted;
               end else begin
                  m_pc    = bt;
                  m_phase = PhFetch;
               end
            end else if (!stl) begin
               m_count = m_count + 1;
               m_pc    = m_pc + 32'd4;
               m_phase = hlt ? PhHalted : PhFetch;
            end
         end
         default: ;
      endcase
   endtask

   task automatic compare_all();
      check_eq("imem_req", {31'b0, imem_req}, {31'b0, m_phase == PhFetch});
      check_eq("instr_valid", {31'b0, instr_valid}, {31'b0, m_phase == PhIssue});
      check_eq("halted", {31'b0, halted}, {31'b0, m_phase == PhHalted});
      check_eq("misaligned_err", {31'b0, misaligned_err}, {31'b0, m_err});
      check_eq("instr_count", instr_count, m_count);
      if (m_phase == PhFetch) check_eq("imem_addr", imem_addr, m_pc);
      if (m_phase == PhIssue || m_phase == PhIdle) begin
         check_eq("instr_out", instr_out, m_instr);
         check_eq("pc_out", pc_out, m_pcout);
      end
   endtask

   // Drive one cycle of inputs, advance the model, then compare after the edge.
   task automatic step(input bit rst, input bit rdy, input bit stl, input bit br,
                       input bit hlt, input logic [31:0] bt, input logic [31:0] rd);
      reset         = rst;
      imem_ready    = rdy;
      stall         = stl;
      branch_taken  = br;
      halt_req      = hlt;
      branch_target = bt;
      imem_rdata    = rd;
      model_step(rst, rdy, stl, br, hlt, bt, rd);
      @(posedge clock);
      @(negedge clock);
      compare_all();
   endtask

   task automatic idle_step(input bit rdy);
      step(1'b0, rdy, 1'b0, 1'b0, 1'b0, 32'h0, $urandom);
   endtask

   initial begin
      model_reset();
      @(negedge clock);

      // Straight-line fetch: pc_out 0, 4, 8 then three consumed.
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h1);
      check_eq("rst_instr_out", instr_out, 32'h0);
      check_eq("rst_pc_out", pc_out, 32'h0);
      idle_step(1'b1);
      check_eq("first_addr", imem_addr, RESET_PC);
      idle_step(1'b1);
      check_eq("seq_pc0", pc_out, 32'h0);
      idle_step(1'b1);
      idle_step(1'b1);
      check_eq("seq_pc4", pc_out, 32'h4);
      idle_step(1'b1);
      idle_step(1'b1);
      check_eq("seq_pc8", pc_out, 32'h8);
      idle_step(1'b1);
      check_eq("seq_count3", instr_count, 32'd3);

      // Stall holds the issued instruction for five cycles.
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hCAFE_F00D);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, $urandom);
      check_eq("stall_instr", instr_out, 32'hCAFE_F00D);
      check_eq("stall_pc", pc_out, 32'hC);
      check_eq("stall_req", {31'b0, imem_req}, 32'h0);
      check_eq("stall_count", instr_count, 32'd3);
      idle_step(1'b0);

      // Redirect during a fetch that completes three cycles later.
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
      idle_step(1'b0);
      idle_step(1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'hDEAD_BEEF);
      check_eq("redir_valid", {31'b0, instr_valid}, 32'h0);
      check_eq("redir_addr", imem_addr, 32'h100);
      idle_step(1'b1);
      check_eq("redir_pc", pc_out, 32'h100);

      // Wrap of pc past 0xFFFF_FFFC.
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0);
      idle_step(1'b1);
      check_eq("wrap_pc", pc_out, 32'hFFFF_FFFC);
      idle_step(1'b0);
      check_eq("wrap_addr", imem_addr, 32'h0);

      // Reset during a fetch with a redirect pending.
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0);
      check_eq("mid_rst_req", {31'b0, imem_req}, 32'h0);
      check_eq("mid_rst_count", instr_count, 32'h0);
      idle_step(1'b0);
      check_eq("mid_rst_addr", imem_addr, RESET_PC);
      idle_step(1'b1);
      check_eq("mid_rst_pc", pc_out, RESET_PC);

      // Misaligned branch target halts for good.
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h102, 32'h0);
      check_eq("mis_err", {31'b0, misaligned_err}, 32'h1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40, $urandom);
      check_eq("mis_halted", {31'b0, halted}, 32'h1);
      check_eq("mis_req", {31'b0, imem_req}, 32'h0);

      // Random traffic.
      for (int ep = 0; ep < 10; ep++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
         for (int c = 0; c < 300; c++) begin
            logic [31:0] bt;
            bt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 4)
                                             : ($urandom & 32'hFFFF_FFFC);
            if ($urandom_range(0, 31) == 0) bt[1:0] = 2'($urandom_range(1, 3));
            step($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 39) == 0, bt, $urandom);
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pc_fetch_sequencer.md
PC_FETCH_SEQUENCER -- requirements
Module: pc_fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC loaded on reset.
REQ-002 SHALL have port clock, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1, reset (synchronous, active-high).
REQ-004 SHALL have port imem_req, output, 1, instruction-memory fetch request.
REQ-005 SHALL have port imem_addr, output, 32, fetch address.
REQ-006 SHALL have port imem_ready, input, 1, fetch complete with imem_rdata valid this cycle.
REQ-007 SHALL have port imem_rdata, input, 32, fetched instruction word.
REQ-008 SHALL have port instr_valid, output, 1, instr_out/pc_out valid for decode.
REQ-009 SHALL have port instr_out, output, 32, held instruction.
REQ-010 SHALL have port pc_out, output, 32, PC of instr_out.
REQ-011 SHALL have port stall, input, 1, decode not accepting the issued instruction.
REQ-012 SHALL have port branch_taken, input, 1, redirect request.
REQ-013 SHALL have port branch_target, input, 32, redirect PC.
REQ-014 SHALL have port halt_req, input, 1, stop after the current instruction.
REQ-015 SHALL have port halted, output, 1, sequencer in HALTED.
REQ-016 SHALL have port misaligned_err, output, 1, sticky misaligned-target flag.
REQ-017 SHALL have port instr_count, output, 32, count of consumed instructions.

Function
REQ-018 SHALL implement the states IDLE, FETCH, ISSUE and HALTED, with all outputs registered.
REQ-019 IDLE: SHALL go to FETCH on the next cycle, or to HALTED if halt_req=1.
REQ-020 FETCH: SHALL drive imem_req=1 and imem_addr=pc, both held stable until imem_ready=1.
REQ-021 FETCH with imem_ready=1 and no pending redirect: SHALL latch imem_rdata into instr_out, set pc_out=pc, and go to ISSUE.
REQ-022 ISSUE: SHALL hold instr_valid=1 with instr_out and pc_out stable while stall=1.
REQ-023 ISSUE, branch_taken=0, stall=0: SHALL set pc=pc+4 modulo 2^32 and increment instr_count; it SHALL then go to HALTED if halt_req=1, else to FETCH.
REQ-024 ISSUE, branch_taken=1: SHALL take priority over stall and halt_req, set pc=branch_target, increment instr_count, and go to FETCH.
REQ-025 FETCH, branch_taken=1: SHALL store branch_target and set redirect_pending while keeping imem_addr unchanged.
REQ-026 When imem_ready=1 with redirect_pending or branch_taken set: SHALL discard the returned data, load the stored or new target into pc, clear redirect_pending, and re-enter FETCH on the next cycle.
REQ-027 On a second redirect while one is pending: SHALL keep the latest target.
REQ-028 If branch_target[1:0]!=0 when a redirect is accepted: SHALL set misaligned_err=1, leave pc unchanged, and go to HALTED.
REQ-029 HALTED: SHALL drive halted=1, imem_req=0 and instr_valid=0, and SHALL ignore all inputs except reset.
REQ-030 instr_valid SHALL be 0 in every state except ISSUE.
REQ-031 halt_req in FETCH SHALL take effect only at the consuming ISSUE edge.
REQ-032 instr_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-033 Fetch latency SHALL be 1 cycle plus imem wait cycles; back-to-back instructions SHALL issue no faster than every 2 cycles.

Reset
REQ-034 On reset=1 at a clock edge, in any state (including mid-fetch or with a redirect pending), SHALL force state=IDLE, pc=RESET_PC, imem_req=0, instr_valid=0, instr_out=0, pc_out=0, halted=0, misaligned_err=0, instr_count=0 and redirect_pending=0.
REQ-035 Reset SHALL take priority over all other inputs.

Verification
REQ-036 Bench SHALL cover: reset, then imem_ready=1 in every fetch cycle -> pc_out 0,4,8 on successive ISSUE cycles and instr_count=3 after three are consumed.
REQ-037 Bench SHALL cover: stall=1 for 5 cycles in ISSUE -> instr_out and pc_out unchanged, no new imem_req, and instr_count unchanged.
REQ-038 Bench SHALL cover: branch_taken=1 with target 0x100 during FETCH while imem_ready is delayed 3 cycles -> data discarded, next imem_addr=0x100, and no instr_valid for the old PC.
REQ-039 Bench SHALL cover: branch target 0x102 -> misaligned_err=1, halted=1 and imem_req=0 thereafter.
REQ-040 Bench SHALL cover: pc=0xFFFF_FFFC consumed -> next imem_addr=0x0000_0000.
REQ-041 Bench SHALL cover: reset asserted during FETCH with a redirect pending -> all outputs at reset values, then fetch from RESET_PC.
